// File: rtl/fast_cmd_decoder_if.sv
// Serial fast-command bus: bit stream and realign request in,
// lock status, frame strobe and one-cycle command pulses out.
interface fast_cmd_decoder_if;
  logic din;
  logic realign;
  logic locked;
  logic frame_strobe;
  logic l1a;
  logic bcr;
  logic link_reset;
  logic sync_trig;
  logic charge_inj;
  logic ws_start;
  logic ws_stop;
  logic invalid;

  // Decoder side
  modport slave (
    input  din, realign,
    output locked, frame_strobe, l1a, bcr, link_reset, sync_trig,
           charge_inj, ws_start, ws_stop, invalid
  );

  // Stream source / command consumer side
  modport master (
    output din, realign,
    input  locked, frame_strobe, l1a, bcr, link_reset, sync_trig,
           charge_inj, ws_start, ws_stop, invalid
  );
endinterface

// File: rtl/fast_cmd_decoder.sv
// Fast-command decoder: hunts for the IDLE pattern in a serial stream,
// confirms alignment over LOCK_CNT frames, then decodes each 8-bit frame
// into registered one-cycle command pulses. ERR_MAX consecutive unknown
// frames (or an explicit realign) drop lock and restart the hunt.
module fast_cmd_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_MAX  = 3
) (
  input  logic               clk,
  input  logic               rstn,
  fast_cmd_decoder_if.slave  bus
);
  localparam logic [7:0] C_IDLE  = 8'hF0;
  localparam logic [7:0] C_LRST  = 8'h33;
  localparam logic [7:0] C_BCR   = 8'h5A;
  localparam logic [7:0] C_SYNC  = 8'h55;
  localparam logic [7:0] C_CHG   = 8'h69;
  localparam logic [7:0] C_L1A   = 8'h96;
  localparam logic [7:0] C_L1B   = 8'h99;
  localparam logic [7:0] C_WSS   = 8'hA5;
  localparam logic [7:0] C_WSP   = 8'hAA;

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  typedef struct packed {
    logic l1a;
    logic bcr;
    logic link_reset;
    logic sync_trig;
    logic charge_inj;
    logic ws_start;
    logic ws_stop;
    logic invalid;
  } cmd_t;

  state_t     state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] w;
  logic [2:0] bit_q, bit_d;
  logic [3:0] good_q, good_d;
  logic [3:0] err_q, err_d;
  logic [3:0] good_inc, err_inc;
  logic       locked_q, locked_d;
  logic       strobe_q, strobe_d;
  cmd_t       cmd_q, cmd_d;
  logic       unused_sr_msb;

  // Candidate word includes the bit arriving at this edge
  assign w             = {sr_q[6:0], bus.din};
  assign good_inc      = good_q + 4'd1;
  assign err_inc       = err_q + 4'd1;
  assign unused_sr_msb = sr_q[7];

  // Next-state: alignment FSM, frame evaluation and command decode
  always_comb begin
    sr_d     = w;
    state_d  = state_q;
    bit_d    = bit_q + 3'd1;
    good_d   = good_q;
    err_d    = err_q;
    locked_d = locked_q;
    strobe_d = 1'b0;
    cmd_d    = '0;
    if (bus.realign) begin
      // realign wins over any frame evaluated at this edge
      state_d  = HUNT;
      bit_d    = 3'd0;
      good_d   = 4'd0;
      err_d    = 4'd0;
      locked_d = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          bit_d = 3'd0;
          if (w == C_IDLE) begin
            state_d = CHECK;
            good_d  = 4'd1;
          end
        end
        CHECK: begin
          if (bit_q == 3'd7) begin
            if (w == C_IDLE) begin
              good_d = good_inc;
              if (good_inc == 4'(LOCK_CNT)) begin
                state_d  = LOCKED;
                locked_d = 1'b1;
              end
            end else begin
              state_d = HUNT;
              bit_d   = 3'd0;
              good_d  = 4'd0;
              err_d   = 4'd0;
            end
          end
        end
        LOCKED: begin
          if (bit_q == 3'd7) begin
            strobe_d = 1'b1;
            err_d    = 4'd0;
            case (w)
              C_IDLE: ;
              C_LRST: cmd_d.link_reset = 1'b1;
              C_BCR:  cmd_d.bcr        = 1'b1;
              C_SYNC: cmd_d.sync_trig  = 1'b1;
              C_CHG:  cmd_d.charge_inj = 1'b1;
              C_L1A:  cmd_d.l1a        = 1'b1;
              C_L1B: begin
                cmd_d.l1a = 1'b1;
                cmd_d.bcr = 1'b1;
              end
              C_WSS:  cmd_d.ws_start   = 1'b1;
              C_WSP:  cmd_d.ws_stop    = 1'b1;
              default: begin
                cmd_d.invalid = 1'b1;
                err_d         = err_inc;
                if (err_inc == 4'(ERR_MAX)) begin
                  state_d  = HUNT;
                  locked_d = 1'b0;
                  bit_d    = 3'd0;
                  good_d   = 4'd0;
                  err_d    = 4'd0;
                end
              end
            endcase
          end
        end
        default: begin
          state_d  = HUNT;
          bit_d    = 3'd0;
          good_d   = 4'd0;
          err_d    = 4'd0;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      bit_q    <= '0;
      good_q   <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      strobe_q <= 1'b0;
      cmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      good_q   <= good_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      strobe_q <= strobe_d;
      cmd_q    <= cmd_d;
    end
  end

  assign bus.locked       = locked_q;
  assign bus.frame_strobe = strobe_q;
  assign bus.l1a          = cmd_q.l1a;
  assign bus.bcr          = cmd_q.bcr;
  assign bus.link_reset   = cmd_q.link_reset;
  assign bus.sync_trig    = cmd_q.sync_trig;
  assign bus.charge_inj   = cmd_q.charge_inj;
  assign bus.ws_start     = cmd_q.ws_start;
  assign bus.ws_stop      = cmd_q.ws_stop;
  assign bus.invalid      = cmd_q.invalid;
endmodule

// File: doc/fast_cmd_decoder.md
FAST_CMD_DECODER -- requirements
Module: fast_cmd_decoder

Interface
REQ-001 SHALL have parameter LOCK_CNT, default 4, meaning the number of consecutive aligned IDLE frames required to lock (range 2..15).
REQ-002 SHALL have parameter ERR_MAX, default 3, meaning the number of consecutive invalid frames while locked that force realignment (range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: fast-command bit clock; all logic runs on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port din, input, 1 bit: serial fast-command stream, MSB of each 8-bit frame first.
REQ-006 SHALL have port realign, input, 1 bit: synchronous request to drop lock and re-hunt.
REQ-007 SHALL have port locked, output, 1 bit: frame alignment achieved.
REQ-008 SHALL have port frame_strobe, output, 1 bit: one-cycle pulse per aligned frame evaluated while LOCKED.
REQ-009 SHALL have ports l1a, bcr, link_reset, sync_trig, charge_inj, ws_start, ws_stop, output, 1 bit each: one-cycle command pulses to the downstream delay stages.
REQ-010 SHALL have port invalid, output, 1 bit: one-cycle pulse when a locked frame matches no code.

Function
REQ-011 SHALL keep an 8-bit shift register sr, updated every edge as sr <= {sr[6:0], din}; candidate word w = {sr[6:0], din}.
REQ-012 SHALL use the fixed codes IDLE 8'hF0, LinkReset 8'h33, BCR 8'h5A, SyncForTrig 8'h55, ChargeInj 8'h69, L1A 8'h96, L1A_BCR 8'h99, WSStart 8'hA5, WSStop 8'hAA.
REQ-013 SHALL implement states HUNT, CHECK, LOCKED with a 3-bit bit counter, a 4-bit good counter and a 4-bit error counter.
REQ-014 In HUNT, at any edge where w == IDLE, the block SHALL go to CHECK with bit counter 0 and good counter 1; otherwise it remains in HUNT.
REQ-015 In CHECK and LOCKED, the bit counter SHALL increment mod 8 every edge, and a frame SHALL be evaluated on w at the edge where the counter equals 7.
REQ-016 In CHECK, an evaluated IDLE SHALL increment the good counter, and reaching LOCK_CNT SHALL enter LOCKED and set locked at that edge.
REQ-017 In CHECK, any non-IDLE evaluated frame SHALL return the block to HUNT with counters cleared and no output pulse.
REQ-018 In LOCKED, every evaluated frame SHALL pulse frame_strobe for one cycle.
REQ-019 In LOCKED, a valid command SHALL pulse its output(s) for exactly one cycle, starting the cycle after the edge that samples the frame's last bit (latency 1 clk), and SHALL clear the error counter.
REQ-020 L1A_BCR SHALL pulse both l1a and bcr in the same cycle.
REQ-021 In LOCKED, IDLE SHALL produce no command pulse and SHALL clear the error counter.
REQ-022 In LOCKED, an unknown code SHALL pulse invalid and increment the error counter.
REQ-023 When the error counter reaches ERR_MAX, the block SHALL go to HUNT with locked cleared at that same edge and the error counter cleared.
REQ-024 realign high at an edge SHALL force HUNT, clear locked and all counters, and suppress all pulses at that edge; realign SHALL take priority over a simultaneous frame evaluation.
REQ-025 Command and invalid outputs SHALL be registered and low in every cycle not covered by REQ-019/022.

Reset
REQ-026 While rstn is low at an edge: sr = 0, state = HUNT, all counters = 0, and all outputs = 0.
REQ-027 Reset asserted mid-frame or while LOCKED SHALL discard the partial frame; after release, relock SHALL require a fresh full LOCK_CNT sequence.

Verification
REQ-028 Continuous IDLE stream at arbitrary bit offset after reset -> locked rises at the edge completing the 4th aligned IDLE; no command pulses.
REQ-029 Locked, then frame 8'h96 -> l1a high exactly 1 cycle after its LSB edge, and frame_strobe is coincident with it.
REQ-030 Locked, then frame 8'h99 -> l1a and bcr high together for 1 cycle.
REQ-031 Locked, then frames 8'h00, 8'h00, 8'h00 -> invalid pulses 3 times and locked falls on the 3rd; with pattern 8'h00, 8'hF0, 8'h00, locked stays high.
REQ-032 CHECK with good counter 2, then a non-IDLE frame -> back to HUNT and locked stays 0.
REQ-033 realign asserted on the same edge as an L1A frame, and rstn pulsed while locked -> no l1a pulse and locked = 0; relock follows after 4 IDLE frames.
